dmac_fifo8_ctrl: RTL and testbench
==================================

Name: dmac_fifo8_ctrl

Overview:
- 8-entry x 32-bit storage and pointer controller for the DMAC descriptor/data queue.
- Sits directly upstream of the 8-to-1 32-bit mux stage: it drives the eight entry words as the mux data inputs and its read pointer as the mux select. The mux output is therefore the FIFO head word.
- It owns all sequential state: entry registers, pointers, occupancy, a status FSM, and the registered ack/error handshake flags.

Parameters:
- DATA_WIDTH, 32, width of each entry; must match the downstream mux data width.
- DEPTH, 8, number of entries; fixed at 8 because the mux is 8-way.
- PTR_WIDTH, 3, pointer width, log2(DEPTH); also the mux select width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  push request, sampled on the rising edge.
- din  in  32  push data.
- rd_en  in  1  pop request, sampled on the rising edge.
- entry0..entry7  out  32 each  stored words; connect to mux inputs a..h.
- rd_ptr  out  3  head index; connects to mux sel.
- wr_ptr  out  3  next write index (debug/observability).
- data_count  out  4  occupancy, 0..8.
- full  out  1  high when data_count == 8.
- empty  out  1  high when data_count == 0.
- wr_ack  out  1  registered; previous-cycle push accepted.
- wr_err  out  1  registered; previous-cycle push rejected.
- rd_ack  out  1  registered; previous-cycle pop accepted.
- rd_err  out  1  registered; previous-cycle pop rejected.

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous-to-clk release):
  - entry0..7 = 0, rd_ptr = 0, wr_ptr = 0, data_count = 0.
  - empty = 1, full = 0, all ack/err = 0.
  - FSM = INIT.
  - Reset mid-operation discards all contents; no partial pointer update survives.
- Push accepted (wr_en=1 and full=0):
  - entry[wr_ptr] <= din.
  - wr_ptr <= wr_ptr+1, modulo 8 (7 wraps to 0).
  - data_count +1.
- Pop accepted (rd_en=1 and empty=0):
  - rd_ptr <= rd_ptr+1, modulo 8.
  - data_count -1.
  - The entry is not cleared. The popped word is the mux output during the rd_en cycle (zero read latency from the mux's view).
- Simultaneous wr_en and rd_en, priority decided as follows:
  - Neither full nor empty: both are accepted, count unchanged, both pointers advance.
  - Full: the pop is accepted and the push is rejected (wr_err). Writes never use the same-cycle freed slot.
  - Empty: the push is accepted and the pop is rejected (rd_err). No fall-through.
- Push while full, no pop: no state change except wr_err.
- Pop while empty, no push: no state change except rd_err.
- full and empty are derived from the next data_count and are registered, so they are valid in the same cycle as the new count.
- Status FSM; the state is registered and the ack/err outputs are decoded from it:
  - States: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR, RW (both accepted).
  - INIT: exits after reset on the first edge with reset_n high.
  - Next state each cycle, by request:
    - No request: NO_OP.
    - Accepted push only: WRITE.
    - Rejected push only: WR_ERROR.
    - Accepted pop only: READ.
    - Rejected pop only: RD_ERROR.
    - Both accepted: RW.
    - Full with both requested: READ with wr_err also set.
    - Empty with both requested: WRITE with rd_err also set.
  - Output decode:
    - wr_ack = 1 in WRITE and RW.
    - rd_ack = 1 in READ and RW.
    - wr_err and rd_err as per the cases above.
  - Flags are one-cycle pulses, cleared in NO_OP and INIT.
- Arithmetic:
  - Pointers are 3-bit with natural wrap.
  - data_count is 4-bit and never exceeds 8 or underflows below 0.

Decomposition:
- Shared package/include (dmac_defs) holds:
  - DATA_WIDTH, DEPTH and PTR_WIDTH constants.
  - FSM state encodings: INIT=3'b000, NO_OP=3'b001, WRITE=3'b010, WR_ERROR=3'b011, READ=3'b100, RD_ERROR=3'b101, RW=3'b110.
- Natural sub-module: dmac_fifo8_ns_logic, a combinational block computing next state, next pointers, next count and accept/reject decisions. The top holds the registers and the entry array.

Test Plan:
- Reset mid-fill: push 3 words, assert reset_n=0 -> immediately count=0, empty=1, rd_ptr=wr_ptr=0, entries=0, acks=0.
- Fill to full: push 0x11111111..0x88888888 on 8 consecutive cycles -> full=1, count=8, wr_ptr=0. A 9th push of 0xDEADBEEF -> wr_err pulse, entry0 stays 0x11111111.
- Drain in order from full: pop 8 times -> mux sel (rd_ptr) 0..7 and head words 0x11111111..0x88888888 in order, rd_ack pulses each cycle, empty=1 after the last pop. A 9th pop -> rd_err, rd_ptr stays 0.
- Wrap-around: push 5, pop 5, then push 6 (0xA0..0xA5) -> wr_ptr wraps 5->7->0->3, rd_ptr=5, count=6, and pops return 0xA0..0xA5 in order.
- Simultaneous at boundaries:
  - Full with wr_en+rd_en -> count 7, rd_ack=1, wr_err=1.
  - Empty with both -> count 1, wr_ack=1, rd_err=1.
  - Count=4 with both -> count 4, both acks=1, state RW.

Source files
------------

// File: rtl/dmac_fifo8_ctrl_pkg.sv
// Shared constants and types for the DMAC 8-entry descriptor/data queue.
// The queue feeds an 8-to-1 32-bit mux, so depth and widths are fixed to
// match that mux.
package dmac_defs;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 8;
  localparam int PTR_WIDTH  = 3;
  localparam int CNT_WIDTH  = 4;

  // Status FSM encodings; the handshake flags are decoded from these.
  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101,
    RW       = 3'b110
  } fifo_state_e;

  // Per-cycle accept/reject outcome of the push and pop requests.
  typedef struct packed {
    logic wr_ok;
    logic rd_ok;
    logic wr_rej;
    logic rd_rej;
  } req_decision_t;

  // Occupancy value that means "every entry holds a word".
  localparam logic [CNT_WIDTH-1:0] COUNT_FULL = CNT_WIDTH'(DEPTH);

endpackage

// File: rtl/dmac_fifo8_ns_logic.sv
// Combinational next-state block: decides which requests are accepted and
// computes the next pointers, occupancy, status flags and FSM state.
module dmac_fifo8_ns_logic
  import dmac_defs::*;
(
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [PTR_WIDTH-1:0] wr_ptr,
  input  logic [PTR_WIDTH-1:0] rd_ptr,
  input  logic [CNT_WIDTH-1:0] data_count,
  input  logic                 full,
  input  logic                 empty,
  output req_decision_t        dec,
  output logic [PTR_WIDTH-1:0] nxt_wr_ptr,
  output logic [PTR_WIDTH-1:0] nxt_rd_ptr,
  output logic [CNT_WIDTH-1:0] nxt_count,
  output logic                 nxt_full,
  output logic                 nxt_empty,
  output fifo_state_e          nxt_state,
  output logic                 nxt_wr_err_x,
  output logic                 nxt_rd_err_x
);

  // Accept/reject: a push needs a free slot now, a pop needs a stored word
  // now. The slot freed by a same-cycle pop is never reused for a push,
  // and a word pushed this cycle never falls through to a pop.
  always_comb begin
    dec.wr_ok  = wr_en & ~full;
    dec.rd_ok  = rd_en & ~empty;
    dec.wr_rej = wr_en & full;
    dec.rd_rej = rd_en & empty;
  end

  // Pointer and occupancy update; 3-bit pointers wrap naturally 7 -> 0.
  always_comb begin
    nxt_wr_ptr = dec.wr_ok ? wr_ptr + PTR_WIDTH'(1) : wr_ptr;
    nxt_rd_ptr = dec.rd_ok ? rd_ptr + PTR_WIDTH'(1) : rd_ptr;
    unique case ({dec.wr_ok, dec.rd_ok})
      2'b10:   nxt_count = data_count + CNT_WIDTH'(1);
      2'b01:   nxt_count = data_count - CNT_WIDTH'(1);
      default: nxt_count = data_count;
    endcase
    nxt_full  = (nxt_count == COUNT_FULL);
    nxt_empty = (nxt_count == '0);
  end

  // Next FSM state by request outcome. When one request is accepted and the
  // other rejected at a boundary, the state reflects the accepted side and
  // the rejected side is carried by a companion error flag.
  always_comb begin
    nxt_state    = NO_OP;
    nxt_wr_err_x = 1'b0;
    nxt_rd_err_x = 1'b0;
    if (dec.wr_ok && dec.rd_ok) begin
      nxt_state = RW;
    end else if (dec.wr_ok) begin
      nxt_state    = WRITE;
      nxt_rd_err_x = dec.rd_rej;
    end else if (dec.rd_ok) begin
      nxt_state    = READ;
      nxt_wr_err_x = dec.wr_rej;
    end else if (dec.wr_rej) begin
      nxt_state = WR_ERROR;
    end else if (dec.rd_rej) begin
      nxt_state = RD_ERROR;
    end
  end

endmodule

// File: rtl/dmac_fifo8_ctrl.sv
// 8 x 32-bit queue storage and pointer controller. Drives the eight entry
// words as mux data inputs and rd_ptr as the mux select, so the mux output
// is the head word with zero read latency. Owns all sequential state.
module dmac_fifo8_ctrl
  import dmac_defs::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] entry0,
  output logic [DATA_WIDTH-1:0] entry1,
  output logic [DATA_WIDTH-1:0] entry2,
  output logic [DATA_WIDTH-1:0] entry3,
  output logic [DATA_WIDTH-1:0] entry4,
  output logic [DATA_WIDTH-1:0] entry5,
  output logic [DATA_WIDTH-1:0] entry6,
  output logic [DATA_WIDTH-1:0] entry7,
  output logic [PTR_WIDTH-1:0]  rd_ptr,
  output logic [PTR_WIDTH-1:0]  wr_ptr,
  output logic [CNT_WIDTH-1:0]  data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  fifo_state_e           state;
  fifo_state_e           nxt_state;
  logic                  wr_err_x;
  logic                  rd_err_x;
  logic                  nxt_wr_err_x;
  logic                  nxt_rd_err_x;
  req_decision_t         dec;
  logic [PTR_WIDTH-1:0]  nxt_wr_ptr;
  logic [PTR_WIDTH-1:0]  nxt_rd_ptr;
  logic [CNT_WIDTH-1:0]  nxt_count;
  logic                  nxt_full;
  logic                  nxt_empty;

  dmac_fifo8_ns_logic u_ns (
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .data_count   (data_count),
    .full         (full),
    .empty        (empty),
    .dec          (dec),
    .nxt_wr_ptr   (nxt_wr_ptr),
    .nxt_rd_ptr   (nxt_rd_ptr),
    .nxt_count    (nxt_count),
    .nxt_full     (nxt_full),
    .nxt_empty    (nxt_empty),
    .nxt_state    (nxt_state),
    .nxt_wr_err_x (nxt_wr_err_x),
    .nxt_rd_err_x (nxt_rd_err_x)
  );

  // Pointer, occupancy, status-flag and FSM state registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      state      <= INIT;
      wr_err_x   <= 1'b0;
      rd_err_x   <= 1'b0;
    end else begin
      wr_ptr     <= nxt_wr_ptr;
      rd_ptr     <= nxt_rd_ptr;
      data_count <= nxt_count;
      full       <= nxt_full;
      empty      <= nxt_empty;
      state      <= nxt_state;
      wr_err_x   <= nxt_wr_err_x;
      rd_err_x   <= nxt_rd_err_x;
    end
  end

  // Entry array: written at wr_ptr on an accepted push, never cleared by a pop.
  // NOTE: the storage is reset on purpose -- the entries are visible ports
  // into the downstream mux and must read as zero after reset; a plain
  // internal RAM would normally be left unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (dec.wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Handshake flag decode from the registered FSM state.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred for states that do not assign it.
  always_comb begin
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    wr_err = wr_err_x;
    rd_err = rd_err_x;
    unique case (state)
      WRITE:    wr_ack = 1'b1;
      READ:     rd_ack = 1'b1;
      RW: begin
        wr_ack = 1'b1;
        rd_ack = 1'b1;
      end
      WR_ERROR: wr_err = 1'b1;
      RD_ERROR: rd_err = 1'b1;
      default: begin
        wr_err = 1'b0;
        rd_err = 1'b0;
      end
    endcase
  end

  // Mux data inputs.
  assign entry0 = mem[0];
  assign entry1 = mem[1];
  assign entry2 = mem[2];
  assign entry3 = mem[3];
  assign entry4 = mem[4];
  assign entry5 = mem[5];
  assign entry6 = mem[6];
  assign entry7 = mem[7];

endmodule

// File: tb/tb_dmac_fifo8_ctrl.sv
// Self-checking bench for dmac_fifo8_ctrl: a table of directed vectors for
// fill/drain/boundary behaviour, plus hand-written sequences for reset
// values, pointer wrap-around and asynchronous reset mid-fill.
module tb_dmac_fifo8_ctrl;
  import dmac_defs::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;
  logic [31:0] entry0, entry1, entry2, entry3, entry4, entry5, entry6, entry7;
  logic [2:0]  rd_ptr;
  logic [2:0]  wr_ptr;
  logic [3:0]  data_count;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;

  int errors = 0;
  int checks = 0;

  dmac_fifo8_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .din        (din),
    .rd_en      (rd_en),
    .entry0     (entry0),
    .entry1     (entry1),
    .entry2     (entry2),
    .entry3     (entry3),
    .entry4     (entry4),
    .entry5     (entry5),
    .entry6     (entry6),
    .entry7     (entry7),
    .rd_ptr     (rd_ptr),
    .wr_ptr     (wr_ptr),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  // The downstream mux: head word selected by rd_ptr.
  logic [31:0] ent [8];
  assign ent[0] = entry0;
  assign ent[1] = entry1;
  assign ent[2] = entry2;
  assign ent[3] = entry3;
  assign ent[4] = entry4;
  assign ent[5] = entry5;
  assign ent[6] = entry6;
  assign ent[7] = entry7;
  logic [31:0] head;
  assign head = ent[rd_ptr];

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] d;
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
    logic        wa;
    logic        wer;
    logic        ra;
    logic        rer;
    logic [2:0]  rp;
    logic [2:0]  wp;
    logic [31:0] head;
    logic [2:0]  st;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic re, input logic [31:0] d,
                     input logic [3:0] cnt, input logic f, input logic e,
                     input logic wa, input logic wer, input logic ra, input logic rer,
                     input logic [2:0] rp, input logic [2:0] wp,
                     input logic [31:0] h, input fifo_state_e st);
    vec_t v;
    v.we = we; v.re = re; v.d = d; v.cnt = cnt; v.full = f; v.empty = e;
    v.wa = wa; v.wer = wer; v.ra = ra; v.rer = rer; v.rp = rp; v.wp = wp;
    v.head = h; v.st = st;
    vecs.push_back(v);
  endtask

  // Drive one request set at the falling edge, let the rising edge take it,
  // and return 1 time unit later so outputs are sampled away from the edge.
  task automatic step(input logic we, input logic re, input logic [31:0] d);
    @(negedge clk);
    wr_en = we;
    rd_en = re;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- vector table ----------------
    for (int k = 1; k <= 8; k++)
      add(1, 0, 32'h1111_1111 * k, 4'(k), k == 8, 0, 1, 0, 0, 0,
          3'd0, 3'(k % 8), 32'h1111_1111, WRITE);
    add(1, 0, 32'hDEAD_BEEF, 4'd8, 1, 0, 0, 1, 0, 0, 3'd0, 3'd0, 32'h1111_1111, WR_ERROR);
    for (int j = 1; j <= 8; j++)
      add(0, 1, 32'h0, 4'(8 - j), 0, j == 8, 0, 0, 1, 0,
          3'(j % 8), 3'd0, 32'h1111_1111 * ((j % 8) + 1), READ);
    add(0, 1, 32'h0, 4'd0, 0, 1, 0, 0, 0, 1, 3'd0, 3'd0, 32'h1111_1111, RD_ERROR);
    // empty with both requested: push wins, pop rejected
    add(1, 1, 32'h55, 4'd1, 0, 0, 1, 0, 0, 1, 3'd0, 3'd1, 32'h55, WRITE);
    add(1, 0, 32'h56, 4'd2, 0, 0, 1, 0, 0, 0, 3'd0, 3'd2, 32'h55, WRITE);
    add(1, 0, 32'h57, 4'd3, 0, 0, 1, 0, 0, 0, 3'd0, 3'd3, 32'h55, WRITE);
    add(1, 0, 32'h58, 4'd4, 0, 0, 1, 0, 0, 0, 3'd0, 3'd4, 32'h55, WRITE);
    // count 4 with both requested: both accepted
    add(1, 1, 32'h59, 4'd4, 0, 0, 1, 0, 1, 0, 3'd1, 3'd5, 32'h56, RW);
    add(1, 0, 32'h5A, 4'd5, 0, 0, 1, 0, 0, 0, 3'd1, 3'd6, 32'h56, WRITE);
    add(1, 0, 32'h5B, 4'd6, 0, 0, 1, 0, 0, 0, 3'd1, 3'd7, 32'h56, WRITE);
    add(1, 0, 32'h5C, 4'd7, 0, 0, 1, 0, 0, 0, 3'd1, 3'd0, 32'h56, WRITE);
    add(1, 0, 32'h5D, 4'd8, 1, 0, 1, 0, 0, 0, 3'd1, 3'd1, 32'h56, WRITE);
    // full with both requested: pop wins, push rejected
    add(1, 1, 32'hEE, 4'd7, 0, 0, 0, 1, 1, 0, 3'd2, 3'd1, 32'h57, READ);
    // idle: flags drop
    add(0, 0, 32'h0, 4'd7, 0, 0, 0, 0, 0, 0, 3'd2, 3'd1, 32'h57, NO_OP);

    // ---------------- reset values ----------------
    wr_en = 1'b0; rd_en = 1'b0; din = '0; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst count", 32'(data_count), 32'd0);
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst ptrs", {26'd0, rd_ptr, wr_ptr}, 32'd0);
    check("rst flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);
    check("rst state", 32'(dut.state), 32'(INIT));
    reset_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].we, vecs[i].re, vecs[i].d);
      check($sformatf("v%0d count", i), 32'(data_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d full/empty", i), {30'd0, full, empty},
            {30'd0, vecs[i].full, vecs[i].empty});
      check($sformatf("v%0d flags wa/we/ra/re", i), {28'd0, wr_ack, wr_err, rd_ack, rd_err},
            {28'd0, vecs[i].wa, vecs[i].wer, vecs[i].ra, vecs[i].rer});
      check($sformatf("v%0d rd_ptr", i), 32'(rd_ptr), 32'(vecs[i].rp));
      check($sformatf("v%0d wr_ptr", i), 32'(wr_ptr), 32'(vecs[i].wp));
      check($sformatf("v%0d head", i), head, vecs[i].head);
      check($sformatf("v%0d state", i), 32'(dut.state), 32'(vecs[i].st));
    end
    check("entry0 after overwrite", entry0, 32'h5D);
    check("entry4 from RW push", entry4, 32'h59);

    // ---------------- wrap-around ----------------
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 32'h100 + 32'(i));
    for (int i = 0; i < 5; i++) step(0, 1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 32'hA0 + 32'(i));
      check($sformatf("wrap wr_ptr %0d", i), 32'(wr_ptr), 32'((5 + i + 1) % 8));
    end
    check("wrap rd_ptr", 32'(rd_ptr), 32'd5);
    check("wrap count", 32'(data_count), 32'd6);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b1; din = '0;
      #1;
      check($sformatf("wrap pop head %0d", i), head, 32'hA0 + 32'(i));
      @(posedge clk);
      #1;
      check($sformatf("wrap pop ack %0d", i), 32'(rd_ack), 32'd1);
    end
    check("wrap drained empty", 32'(empty), 32'd1);
    check("wrap drained rd_ptr", 32'(rd_ptr), 32'd3);

    // ---------------- reset mid-fill ----------------
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 32'hC0 + 32'(i));
    check("midfill count before reset", 32'(data_count), 32'd3);
    #2;
    wr_en   = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midfill count", 32'(data_count), 32'd0);
    check("midfill empty/full", {30'd0, empty, full}, 32'd2);
    check("midfill ptrs", {26'd0, rd_ptr, wr_ptr}, 32'd0);
    check("midfill flags", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("midfill entry%0d", i), ent[i], 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
